// File: rtl/ex_div.sv
// Iterative restoring divider for the EX stage (DIV / DIVU).
// Holds stall_req while iterating; ready, quo and rem are valid only in the END cycle.
module ex_div #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             annul,
  output logic             stall_req,
  output logic             ready,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  typedef enum logic [1:0] {StIdle, StByZero, StOn, StEnd} state_e;

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dvd;   // remaining dividend bits, quotient shifted in from the bottom
  logic [WIDTH-1:0] r_dsr;
  logic [WIDTH-1:0] r_part;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_ready;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_qbit;
  logic [WIDTH-1:0] w_part_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_dvd_abs;
  logic [WIDTH-1:0] w_dsr_abs;
  logic             w_last;

  always_comb begin
    w_shift    = {r_part, r_dvd[WIDTH-1]};
    w_diff     = w_shift - {1'b0, r_dsr};
    w_qbit     = ~w_diff[WIDTH];
    w_part_nxt = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    w_quo_nxt  = {r_dvd[WIDTH-2:0], w_qbit};
    w_dvd_abs  = (signed_div && dividend[WIDTH-1]) ? -dividend : dividend;
    w_dsr_abs  = (signed_div && divisor[WIDTH-1]) ? -divisor : divisor;
    w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_dsr   <= '0;
      r_part  <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_ready <= 1'b0;
      r_quo   <= '0;
      r_rem   <= '0;
    end else begin
      r_ready <= 1'b0;
      r_quo   <= '0;
      r_rem   <= '0;
      if (annul) begin
        r_state <= StIdle;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (start) begin
              if (divisor == '0) begin
                r_state <= StByZero;
              end else begin
                r_state <= StOn;
                r_cnt   <= '0;
                r_part  <= '0;
                r_dvd   <= w_dvd_abs;
                r_dsr   <= w_dsr_abs;
                r_neg_q <= signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                r_neg_r <= signed_div & dividend[WIDTH-1];
              end
            end
          end
          StByZero: begin
            r_state <= StEnd;
            r_ready <= 1'b1;
          end
          StOn: begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_part <= w_part_nxt;
            r_dvd  <= w_quo_nxt;
            if (w_last) begin
              r_state <= StEnd;
              r_ready <= 1'b1;
              r_quo   <= r_neg_q ? -w_quo_nxt : w_quo_nxt;
              r_rem   <= r_neg_r ? -w_part_nxt : w_part_nxt;
            end
          end
          StEnd: begin
            r_state <= StIdle;
          end
          default: begin
            r_state <= StIdle;
          end
        endcase
      end
    end
  end

  always_comb begin
    stall_req = !annul && ((r_state == StIdle && start) || r_state == StOn ||
                           r_state == StByZero);
    ready     = r_ready;
    quo       = r_quo;
    rem       = r_rem;
  end

endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: latency, signed/unsigned results, divide by zero,
// overflow, annul, reset mid-operation and back-to-back divisions.
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        annul;
  logic        stall_req;
  logic        ready;
  logic [31:0] quo;
  logic [31:0] rem;

  int checks = 0;
  int errors = 0;

  ex_div #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_div(signed_div),
    .dividend  (dividend),
    .divisor   (divisor),
    .annul     (annul),
    .stall_req (stall_req),
    .ready     (ready),
    .quo       (quo),
    .rem       (rem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Starts a division in the current cycle (cycle 0) and checks every cycle up to ready.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [31:0] eq, input logic [31:0] er,
                         input int lat, input bit keep_start);
    start      = 1'b1;
    signed_div = sgn;
    dividend   = a;
    divisor    = b;
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      if (c < lat) begin
        chk({tag, " stall"}, {31'd0, stall_req}, 32'd1);
        chk({tag, " busy_ready"}, {31'd0, ready}, 32'd0);
      end else begin
        chk({tag, " end_stall"}, {31'd0, stall_req}, 32'd0);
        chk({tag, " ready"}, {31'd0, ready}, 32'd1);
        chk({tag, " quo"}, quo, eq);
        chk({tag, " rem"}, rem, er);
      end
      next_cycle();
      // Operands are not re-sampled once the division is running.
      if (c == 3) begin
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h0000_0001;
      end
    end
    if (!keep_start) begin
      start = 1'b0;
      @(negedge clk);
      chk({tag, " post_ready"}, {31'd0, ready}, 32'd0);
      chk({tag, " post_quo"}, quo, 32'd0);
      next_cycle();
    end
  endtask

  initial begin
    bit saw_ready;
    rst        = 1'b0;
    start      = 1'b0;
    signed_div = 1'b0;
    dividend   = '0;
    divisor    = '0;
    annul      = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("reset ready", {31'd0, ready}, 32'd0);
    chk("reset quo", quo, 32'd0);
    chk("reset rem", rem, 32'd0);
    chk("reset stall", {31'd0, stall_req}, 32'd0);
    next_cycle();
    rst = 1'b1;
    next_cycle();

    run_div("udiv_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33, 1'b0);
    run_div("sdiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 1'b0);
    run_div("udiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 33, 1'b0);
    run_div("div_zero", 32'd5, 32'd0, 1'b0, 32'd0, 32'd0, 2, 1'b0);
    run_div("sdiv_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 33, 1'b0);
    run_div("udiv_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 33, 1'b0);
    run_div("sdiv_20_m3", 32'd20, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFA, 32'd2, 33, 1'b0);

    // Annul in cycle 10 with start dropped.
    start      = 1'b1;
    signed_div = 1'b0;
    dividend   = 32'd100;
    divisor    = 32'd7;
    for (int c = 0; c < 10; c++) next_cycle();
    start = 1'b0;
    annul = 1'b1;
    @(negedge clk);
    chk("annul stall_c10", {31'd0, stall_req}, 32'd0);
    next_cycle();
    annul = 1'b0;
    @(negedge clk);
    chk("annul stall_c11", {31'd0, stall_req}, 32'd0);
    chk("annul ready_c11", {31'd0, ready}, 32'd0);
    saw_ready = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ready) saw_ready = 1'b1;
    end
    chk("annul no_ready", {31'd0, saw_ready}, 32'd0);
    next_cycle();

    // Annul together with start in IDLE keeps the divider idle.
    start = 1'b1;
    annul = 1'b1;
    @(negedge clk);
    chk("annul_idle stall", {31'd0, stall_req}, 32'd0);
    next_cycle();
    start = 1'b0;
    annul = 1'b0;
    @(negedge clk);
    chk("annul_idle state", {31'd0, stall_req}, 32'd0);
    next_cycle();

    // Synchronous reset in cycle 20 of a running division.
    start    = 1'b1;
    dividend = 32'd100;
    divisor  = 32'd7;
    for (int c = 0; c < 20; c++) next_cycle();
    rst = 1'b0;
    next_cycle();
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("rst_mid ready", {31'd0, ready}, 32'd0);
    chk("rst_mid quo", quo, 32'd0);
    chk("rst_mid rem", rem, 32'd0);
    chk("rst_mid stall", {31'd0, stall_req}, 32'd0);
    next_cycle();

    // Back-to-back: ready in cycle 33 and cycle 67.
    run_div("b2b_first", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33, 1'b1);
    run_div("b2b_second", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 33, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
